// File: rtl/riscv_ifetch_queue_pkg.sv
// Shared configuration and types for the instruction prefetch queue.
package riscv_ifetch_queue_pkg;

    // Architectural word width and project-wide queue defaults.
    localparam int unsigned XLEN                = 32;
    localparam int unsigned IFQ_DEPTH           = 4;
    localparam int unsigned IFQ_MAX_OUTSTANDING = 2;

    // Sequential fetches advance by one 32-bit instruction word.
    localparam logic [XLEN-1:0] IFQ_PC_STEP = XLEN'(4);

    // One buffered instruction as presented to the core.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    // Next sequential fetch address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] ifq_next_pc(input logic [XLEN-1:0] pc);
        return pc + IFQ_PC_STEP;
    endfunction

endpackage

// File: rtl/riscv_ifetch_queue_fifo.sv
// Synchronous FIFO with flush and occupancy outputs; head entry is read
// straight from the storage register, with no push-to-pop bypass.
module riscv_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW + 1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer next-state; flush discards all contents and wins over push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/riscv_ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit
// limit, buffers returned {pc, instr} pairs and flushes on redirect.
module riscv_ifetch_queue
    import riscv_ifetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH           = IFQ_DEPTH,
    parameter int unsigned     MAX_OUTSTANDING = IFQ_MAX_OUTSTANDING,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    output logic            o_ifq_valid,
    output logic [XLEN-1:0] o_ifq_instr,
    output logic [XLEN-1:0] o_ifq_pc,
    input  logic            i_ifq_ready,
    input  logic            i_ifq_redirect,
    input  logic [XLEN-1:0] i_ifq_redirect_pc,
    output logic            o_ifq_mem_req,
    output logic [XLEN-1:0] o_ifq_mem_addr,
    input  logic            i_ifq_mem_gnt,
    input  logic            i_ifq_mem_rvalid,
    input  logic [XLEN-1:0] i_ifq_mem_rdata
);

    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PCQ_DEPTH = (MAX_OUTSTANDING < 2) ? 2 : MAX_OUTSTANDING;
    localparam int unsigned PCQ_CNT_W = $clog2(PCQ_DEPTH) + 1;
    localparam int unsigned SUM_W     = CNT_W + OUT_W;

    logic [XLEN-1:0]      fpc_q, fpc_d;
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic [OUT_W-1:0]     discard_q, discard_d;

    logic                 req;
    logic                 fire;
    logic                 rv_ok;
    logic                 rv_keep;
    logic [SUM_W-1:0]     credit_used;

    logic [XLEN-1:0]      pcq_head;
    logic [PCQ_CNT_W-1:0] pcq_count;
    logic                 pcq_full;
    logic                 pcq_empty;

    ifq_entry_t           ifq_wdata;
    ifq_entry_t           ifq_head;
    logic [CNT_W-1:0]     ifq_count;
    logic                 ifq_full;
    logic                 ifq_empty;
    logic                 ifq_pop;

    logic                 unused_status;

    // Occupancy of the PC queue mirrors outstanding; only the head is needed.
    assign unused_status = ^{pcq_count, pcq_full, pcq_empty, ifq_full};

    // Every in-flight request already owns a FIFO slot, so the buffer cannot overflow.
    assign credit_used   = SUM_W'(outstanding_q) + SUM_W'(ifq_count);
    assign req           = i_rstn & ~i_ifq_redirect
                         & (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                         & (credit_used < SUM_W'(DEPTH));
    assign fire          = req & i_ifq_mem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rv_ok         = i_rstn & i_ifq_mem_rvalid & (outstanding_q != '0);
    assign rv_keep       = rv_ok & (discard_q == '0);

    assign o_ifq_mem_req  = req;
    assign o_ifq_mem_addr = fpc_q;

    assign o_ifq_valid   = i_rstn & ~ifq_empty;
    assign o_ifq_pc      = ifq_head.pc;
    assign o_ifq_instr   = ifq_head.instr;
    assign ifq_pop       = o_ifq_valid & i_ifq_ready & ~i_ifq_redirect;

    assign ifq_wdata.pc    = pcq_head;
    assign ifq_wdata.instr = i_ifq_mem_rdata;

    // Fetch address, in-flight count and discard count next-state.
    always_comb begin
        fpc_d         = fpc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (fire && !rv_ok) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!fire && rv_ok) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (i_ifq_redirect) begin
            fpc_d = i_ifq_redirect_pc;
            // outstanding already counts responses marked for discard, so every
            // response still owed after this cycle is dropped; this accumulates
            // correctly across back-to-back redirects.
            discard_d = outstanding_q - OUT_W'(rv_ok);
        end else begin
            if (fire) begin
                fpc_d = ifq_next_pc(fpc_q);
            end
            if (rv_ok && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fpc_q         <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fpc_q         <= fpc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Addresses of granted requests awaiting their response, in order.
    riscv_fifo #(
        .WIDTH (XLEN),
        .DEPTH (PCQ_DEPTH)
    ) u_pc_queue (
        .clk_i   (i_clk),
        .rstn_i  (i_rstn),
        .flush_i (1'b0),
        .push_i  (fire),
        .wdata_i (fpc_q),
        .pop_i   (rv_ok),
        .rdata_o (pcq_head),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    // Returned instructions waiting for the core.
    riscv_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk_i   (i_clk),
        .rstn_i  (i_rstn),
        .flush_i (i_ifq_redirect),
        .push_i  (rv_keep),
        .wdata_i (ifq_wdata),
        .pop_i   (ifq_pop),
        .rdata_o (ifq_head),
        .count_o (ifq_count),
        .full_o  (ifq_full),
        .empty_o (ifq_empty)
    );

endmodule

// File: tb/tb_riscv_ifetch_queue.sv
// Self-checking bench for riscv_ifetch_queue with a latency-configurable
// memory model and an in-order scoreboard of delivered instructions.
module tb_riscv_ifetch_queue;
    import riscv_ifetch_queue_pkg::*;

    localparam int unsigned     TB_DEPTH = 4;
    localparam int unsigned     TB_MAXO  = 2;
    localparam logic [31:0]     TB_RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ifq_valid;
    logic [31:0] ifq_instr;
    logic [31:0] ifq_pc;
    logic        mem_req;
    logic [31:0] mem_addr;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned lat    = 1;
    int unsigned grants = 0;
    int unsigned pops   = 0;
    int unsigned tb_out = 0;
    logic [31:0] exp_fpc = TB_RPC;
    logic [31:0] last_grant_addr = '0;
    bit          stray  = 1'b0;
    bit          arm    = 1'b0;
    bit          first_seen = 1'b0;
    logic [31:0] first_pc = '0;
    logic        s_valid, s_req, s_fire;
    logic [31:0] s_addr;
    int unsigned s_cyc;

    riscv_ifetch_queue #(
        .DEPTH           (TB_DEPTH),
        .MAX_OUTSTANDING (TB_MAXO),
        .RESET_PC        (TB_RPC)
    ) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .o_ifq_valid       (ifq_valid),
        .o_ifq_instr       (ifq_instr),
        .o_ifq_pc          (ifq_pc),
        .i_ifq_ready       (ready),
        .i_ifq_redirect    (redirect),
        .i_ifq_redirect_pc (redirect_pc),
        .o_ifq_mem_req     (mem_req),
        .o_ifq_mem_addr    (mem_addr),
        .i_ifq_mem_gnt     (gnt),
        .i_ifq_mem_rvalid  (rvalid),
        .i_ifq_mem_rdata   (rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: sample and check outputs, update the models, advance.
    task automatic cycle();
        logic fire;
        logic rv_ok;
        logic [31:0] got;
        #2;
        s_valid = ifq_valid;
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_cyc   = cyc;
        fire    = rstn & mem_req & gnt;
        s_fire  = fire;
        rv_ok   = rstn & rvalid & (tb_out != 0);

        if (!rstn) begin
            checks++;
            if (ifq_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid: got %b want 0 (cyc %0d)", ifq_valid, cyc);
            end
            checks++;
            if (mem_req !== 1'b0) begin
                errors++; $display("FAIL reset_req: got %b want 0 (cyc %0d)", mem_req, cyc);
            end
        end else begin
            if (redirect) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++; $display("FAIL redirect_req: got %b want 0 (cyc %0d)", mem_req, cyc);
                end
                exp_q.delete();
            end else begin
                if (tb_out == TB_MAXO) begin
                    checks++;
                    if (mem_req !== 1'b0) begin
                        errors++; $display("FAIL credit_req: got %b want 0 with %0d outstanding (cyc %0d)", mem_req, tb_out, cyc);
                    end
                end
                if (ifq_valid === 1'b1 && ready) begin
                    pops++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL pop_unexpected: got pc %h want none (cyc %0d)", ifq_pc, cyc);
                    end else begin
                        got = exp_q.pop_front();
                        if (ifq_pc !== got) begin
                            errors++; $display("FAIL pop_pc: got %h want %h (cyc %0d)", ifq_pc, got, cyc);
                        end
                        checks++;
                        if (ifq_instr !== mem_word(got)) begin
                            errors++; $display("FAIL pop_instr: got %h want %h (cyc %0d)", ifq_instr, mem_word(got), cyc);
                        end
                    end
                    if (arm) begin
                        arm = 1'b0;
                        first_seen = 1'b1;
                        first_pc = ifq_pc;
                    end
                end
            end
            if (mem_req === 1'b1) begin
                checks++;
                if (mem_addr !== exp_fpc) begin
                    errors++; $display("FAIL req_addr: got %h want %h (cyc %0d)", mem_addr, exp_fpc, cyc);
                end
            end
        end

        if (fire) begin
            pend.push_back('{addr: mem_addr, due: cyc + lat});
            exp_q.push_back(mem_addr);
            last_grant_addr = mem_addr;
            grants++;
        end
        tb_out = tb_out + (fire ? 1 : 0) - (rv_ok ? 1 : 0);

        if (!rstn) exp_fpc = TB_RPC;
        else if (redirect) exp_fpc = redirect_pc;
        else if (fire) exp_fpc = exp_fpc + 32'd4;

        if (!rstn) begin
            pend.delete();
            exp_q.delete();
            tb_out = 0;
        end

        @(posedge clk);
        cyc++;
        #1;
        if (stray) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0; redirect = 1'b0; gnt = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
    endtask

    // Stop issuing, consume everything owed, and confirm the queue goes empty.
    task automatic drain();
        int n;
        gnt = 1'b0; ready = 1'b1; redirect = 1'b0;
        n = 0;
        while (!(exp_q.size() == 0 && pend.size() == 0 && tb_out == 0) && n < 60) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++; $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got valid %b want 0", s_valid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; gnt = 1'b1; ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (s_addr !== TB_RPC) begin
            errors++; $display("FAIL reset_addr: got %h want %h", s_addr, TB_RPC);
        end
        cycle();
        rstn = 1'b1; gnt = 1'b0;
    endtask

    task automatic test_stream();
        int fg, fv;
        int unsigned g0;
        apply_reset();
        lat = 1; gnt = 1'b1; ready = 1'b1;
        g0 = grants; fg = -1; fv = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_fire && fg < 0) fg = int'(s_cyc);
            if (s_valid === 1'b1 && fv < 0) fv = int'(s_cyc);
        end
        checks++;
        if (grants - g0 != 12) begin
            errors++; $display("FAIL stream_grants: got %0d want 12", grants - g0);
        end
        checks++;
        if (fg < 0 || fv - fg != 2) begin
            errors++; $display("FAIL stream_latency: got %0d want 2", fv - fg);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int unsigned g0;
        apply_reset();
        lat = 1; gnt = 1'b1; ready = 1'b0;
        g0 = grants;
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (grants - g0 != TB_DEPTH) begin
            errors++; $display("FAIL bp_grants: got %0d want %0d", grants - g0, TB_DEPTH);
        end
        checks++;
        if (s_req !== 1'b0) begin
            errors++; $display("FAIL bp_req_low: got %b want 0", s_req);
        end
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        g0 = grants;
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (grants - g0 != 1) begin
            errors++; $display("FAIL bp_one_more: got %0d want 1", grants - g0);
        end
        checks++;
        if (last_grant_addr !== 32'h10) begin
            errors++; $display("FAIL bp_addr: got %h want 00000010", last_grant_addr);
        end
        drain();
    endtask

    task automatic test_latency();
        int unsigned g0, p0;
        lat = 3; gnt = 1'b1; ready = 1'b1;
        g0 = grants; p0 = pops;
        for (int i = 0; i < 24; i++) cycle();
        checks++;
        if (grants - g0 != 12) begin
            errors++; $display("FAIL lat_grants: got %0d want 12", grants - g0);
        end
        drain();
        checks++;
        if (pops - p0 != grants - g0) begin
            errors++; $display("FAIL lat_count: got %0d delivered want %0d", pops - p0, grants - g0);
        end
    endtask

    task automatic test_redirect();
        int n;
        lat = 3; gnt = 1'b1; ready = 1'b1;
        n = 0;
        while (tb_out != 2 && n < 20) begin cycle(); n++; end
        checks++;
        if (n >= 20) begin
            errors++; $display("FAIL redir_setup: got %0d outstanding want 2", tb_out);
        end
        redirect = 1'b1; redirect_pc = 32'h100; arm = 1'b1; first_seen = 1'b0;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL redir_valid: got %b want 0", s_valid);
        end
        for (int i = 0; i < 10; i++) cycle();
        drain();
        checks++;
        if (!first_seen || first_pc !== 32'h100) begin
            errors++; $display("FAIL redir_first_pc: got %h want 00000100", first_pc);
        end
    endtask

    task automatic test_redirect_rvalid();
        int n;
        lat = 3; gnt = 1'b1; ready = 1'b0;
        n = 0;
        while (!(rvalid === 1'b1 && ifq_valid === 1'b1 && tb_out == 2) && n < 40) begin
            cycle(); n++;
        end
        checks++;
        if (n >= 40) begin
            errors++; $display("FAIL rr_setup: got %0d outstanding want 2", tb_out);
        end
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; arm = 1'b1; first_seen = 1'b0;
        cycle();
        redirect = 1'b0;
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL rr_valid: got %b want 0", s_valid);
        end
        for (int i = 0; i < 10; i++) cycle();
        drain();
        checks++;
        if (!first_seen || first_pc !== 32'h200) begin
            errors++; $display("FAIL rr_first_pc: got %h want 00000200", first_pc);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        lat = 3; gnt = 1'b1; ready = 1'b1;
        n = 0;
        while (tb_out == 0 && n < 10) begin cycle(); n++; end
        cycle();
        rstn = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        cycle();
        redirect = 1'b0; stray = 1'b1;
        cycle();
        checks++;
        if (s_addr !== TB_RPC) begin
            errors++; $display("FAIL rst_mid_addr: got %h want %h", s_addr, TB_RPC);
        end
        rstn = 1'b1; gnt = 1'b0;
        cycle();
        stray = 1'b0;
        cycle();
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++; $display("FAIL stray_valid: got %b want 0", s_valid);
        end
        checks++;
        if (s_req !== 1'b1 || s_addr !== TB_RPC) begin
            errors++; $display("FAIL stray_restart: got req %b addr %h want 1 %h", s_req, s_addr, TB_RPC);
        end
        lat = 1; gnt = 1'b1; arm = 1'b1; first_seen = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        drain();
        checks++;
        if (!first_seen || first_pc !== TB_RPC) begin
            errors++; $display("FAIL rst_first_pc: got %h want %h", first_pc, TB_RPC);
        end
    endtask

    initial begin
        rstn = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_redirect();
        test_redirect_rvalid();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
